// File: rtl/npc_axi_pkg.sv
// Shared encodings and FSM state types for the AXI burst splitter.
package npc_axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

  typedef enum logic [2:0] {W_IDLE, W_DATA, W_REQ, W_RESP, W_BRESP} w_state_e;

  // Bursts the splitter cannot honour exactly; they are still run as INCR.
  function automatic logic unsupported_burst(input logic [2:0] size, input logic [1:0] burst);
    return (size > 3'd2) || (burst == BURST_WRAP);
  endfunction

endpackage

// File: rtl/axi_beat_addr.sv
// Address of one beat within a burst; FIXED repeats the base, anything else increments.
module axi_beat_addr
  import npc_axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [7:0]        beat,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] offset;

  always_comb begin
    offset = ADDR_W'(beat) << size;
    addr   = (burst == BURST_FIXED) ? base : base + offset;
  end

endmodule

// File: rtl/axi_burst_splitter.sv
// Splits AXI4 read/write bursts into single-beat downstream transactions.
// Optional macro AXI_SPLIT_ERR_EN enables SLVERR reporting for unsupported bursts.
module axi_burst_splitter
  import npc_axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [ID_W-1:0]     s_awid,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [7:0]          s_awlen,
  input  logic [2:0]          s_awsize,
  input  logic [1:0]          s_awburst,
  input  logic                s_wvalid,
  output logic                s_wready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wlast,
  output logic                s_bvalid,
  input  logic                s_bready,
  output logic [ID_W-1:0]     s_bid,
  output logic [1:0]          s_bresp,
  input  logic                s_arvalid,
  output logic                s_arready,
  input  logic [ID_W-1:0]     s_arid,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic [7:0]          s_arlen,
  input  logic [2:0]          s_arsize,
  input  logic [1:0]          s_arburst,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic [ID_W-1:0]     s_rid,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rlast,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [ADDR_W-1:0]   m_araddr,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [DATA_W-1:0]   m_rdata
);

  // Read path
  r_state_e          r_state_q, r_state_d;
  logic [ID_W-1:0]   r_id_q, r_id_d;
  logic [ADDR_W-1:0] r_base_q, r_base_d;
  logic [7:0]        r_len_q, r_len_d, r_beat_q, r_beat_d;
  logic [2:0]        r_size_q, r_size_d;
  logic [1:0]        r_burst_q, r_burst_d;
  logic              r_last;

  assign r_last = (r_beat_q == r_len_q);

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_base_d  = r_base_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_beat_d  = r_beat_q;
    s_arready = 1'b0;
    m_arvalid = 1'b0;
    s_rvalid  = 1'b0;
    m_rready  = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        s_arready = 1'b1;
        if (s_arvalid) begin
          r_id_d    = s_arid;
          r_base_d  = s_araddr;
          r_len_d   = s_arlen;
          r_size_d  = s_arsize;
          r_burst_d = s_arburst;
          r_beat_d  = 8'd0;
          r_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) r_state_d = R_DATA;
      end
      R_DATA: begin
        s_rvalid = m_rvalid;
        m_rready = s_rready;
        if (m_rvalid && s_rready) begin
          if (r_last) begin
            r_state_d = R_IDLE;
          end else begin
            r_beat_d  = r_beat_q + 8'd1;
            r_state_d = R_ADDR;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_base_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_beat_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_base_q  <= r_base_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_beat_q  <= r_beat_d;
    end
  end

  assign s_rid   = r_id_q;
  assign s_rdata = m_rdata;
  assign s_rlast = (r_state_q == R_DATA) && r_last;

  axi_beat_addr #(.ADDR_W(ADDR_W)) u_rd_addr (
    .base  (r_base_q),
    .beat  (r_beat_q),
    .size  (r_size_q),
    .burst (r_burst_q),
    .addr  (m_araddr)
  );

  // Write path
  w_state_e            w_state_q, w_state_d;
  logic [ID_W-1:0]     w_id_q, w_id_d;
  logic [ADDR_W-1:0]   w_base_q, w_base_d;
  logic [7:0]          w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic [2:0]          w_size_q, w_size_d;
  logic [1:0]          w_burst_q, w_burst_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic [DATA_W/8-1:0] w_strb_q, w_strb_d;
  logic                aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_base_d  = w_base_q;
    w_len_d   = w_len_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_beat_d  = w_beat_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    s_bvalid  = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        s_awready = 1'b1;
        if (s_awvalid) begin
          w_id_d    = s_awid;
          w_base_d  = s_awaddr;
          w_len_d   = s_awlen;
          w_size_d  = s_awsize;
          w_burst_d = s_awburst;
          w_beat_d  = 8'd0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        s_wready = 1'b1;
        if (s_wvalid) begin
          w_data_d  = s_wdata;
          w_strb_d  = s_wstrb;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
          w_state_d = W_REQ;
        end
      end
      W_REQ: begin
        // AW and W channels complete independently, possibly in the same cycle.
        m_awvalid = aw_pend_q;
        m_wvalid  = w_pend_q;
        if (m_awready) aw_pend_d = 1'b0;
        if (m_wready) w_pend_d = 1'b0;
        if ((!aw_pend_q || m_awready) && (!w_pend_q || m_wready)) w_state_d = W_RESP;
      end
      W_RESP: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          if (w_beat_q == w_len_q) begin
            w_state_d = W_BRESP;
          end else begin
            w_beat_d  = w_beat_q + 8'd1;
            w_state_d = W_DATA;
          end
        end
      end
      W_BRESP: begin
        s_bvalid = 1'b1;
        if (s_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_base_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_beat_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_base_q  <= w_base_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_beat_q  <= w_beat_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
    end
  end

  assign s_bid   = w_id_q;
  assign m_wdata = w_data_q;
  assign m_wstrb = w_strb_q;

  axi_beat_addr #(.ADDR_W(ADDR_W)) u_wr_addr (
    .base  (w_base_q),
    .beat  (w_beat_q),
    .size  (w_size_q),
    .burst (w_burst_q),
    .addr  (m_awaddr)
  );

`ifdef AXI_SPLIT_ERR_EN
  logic r_err_q, w_err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_err_q <= 1'b0;
      w_err_q <= 1'b0;
    end else begin
      if (r_state_q == R_IDLE && s_arvalid) r_err_q <= unsupported_burst(s_arsize, s_arburst);
      if (w_state_q == W_IDLE && s_awvalid) begin
        w_err_q <= unsupported_burst(s_awsize, s_awburst);
      end else if (w_state_q == W_DATA && s_wvalid && (s_wlast != (w_beat_q == w_len_q))) begin
        w_err_q <= 1'b1;
      end
    end
  end

  assign s_rresp = r_err_q ? RESP_SLVERR : RESP_OKAY;
  assign s_bresp = w_err_q ? RESP_SLVERR : RESP_OKAY;
`else
  logic unused_wlast;
  assign unused_wlast = s_wlast;
  assign s_rresp      = RESP_OKAY;
  assign s_bresp      = RESP_OKAY;
`endif

endmodule

// File: tb/tb_axi_burst_splitter.sv
// Directed and randomized bench for axi_burst_splitter against a burst-level reference model.
module tb_axi_burst_splitter;

  logic        clock, reset;
  logic        s_awvalid, s_awready;
  logic [3:0]  s_awid;
  logic [31:0] s_awaddr;
  logic [7:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst;
  logic        s_wvalid, s_wready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wlast;
  logic        s_bvalid, s_bready;
  logic [3:0]  s_bid;
  logic [1:0]  s_bresp;
  logic        s_arvalid, s_arready;
  logic [3:0]  s_arid;
  logic [31:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_rvalid, s_rready;
  logic [3:0]  s_rid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        m_awvalid, m_awready;
  logic [31:0] m_awaddr;
  logic        m_wvalid, m_wready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_bvalid, m_bready;
  logic        m_arvalid, m_arready;
  logic [31:0] m_araddr;
  logic        m_rvalid, m_rready;
  logic [31:0] m_rdata;

  int n_cmp = 0;
  int n_fail = 0;

  axi_burst_splitter #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .clock(clock), .reset(reset),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: FIXED repeats the base, otherwise base + beat * bytes-per-beat, mod 2^32.
  function automatic logic [31:0] beat_addr(input logic [31:0] base, input int b, input int size,
                                            input int burst);
    if (burst == 0) return base;
    return base + 32'(b * (1 << size));
  endfunction

  task automatic rd_burst(input logic [3:0] id, input logic [31:0] base, input int len,
                          input int size, input int burst, input int stall_beat,
                          input int stall_cyc, input int abort_beat);
    logic [31:0] d;
    int dly;
    @(negedge clock);
    chk("arready_idle", s_arready, 1);
    s_arvalid = 1'b1; s_arid = id; s_araddr = base;
    s_arlen = 8'(len); s_arsize = 3'(size); s_arburst = 2'(burst);
    @(negedge clock);
    s_arvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      dly = $urandom_range(0, 2);
      for (int c = 0; c <= dly; c++) begin
        chk("m_arvalid", m_arvalid, 1);
        chk("m_araddr", m_araddr, beat_addr(base, b, size, burst));
        if (c == dly) m_arready = 1'b1;
        @(negedge clock);
      end
      m_arready = 1'b0;
      chk("m_arvalid_drop", m_arvalid, 0);
      d = $urandom;
      m_rvalid = 1'b1; m_rdata = d;
      if (b == abort_beat) begin
        reset = 1'b1;
        #1;
        chk("rst_s_rvalid", s_rvalid, 0);
        chk("rst_m_arvalid", m_arvalid, 0);
        @(negedge clock);
        reset = 1'b0; m_rvalid = 1'b0;
        #1;
        chk("rst_arready", s_arready, 1);
        return;
      end
      if (b == stall_beat) begin
        for (int c = 0; c < stall_cyc; c++) begin
          #1;
          chk("stall_rvalid", s_rvalid, 1);
          chk("stall_m_rready", m_rready, 0);
          chk("stall_rdata", s_rdata, d);
          @(negedge clock);
        end
      end
      s_rready = 1'b1;
      #1;
      chk("s_rvalid", s_rvalid, 1);
      chk("m_rready", m_rready, 1);
      chk("s_rdata", s_rdata, d);
      chk("s_rid", s_rid, id);
      chk("s_rlast", s_rlast, (b == len));
      chk("s_rresp", s_rresp, 0);
      @(negedge clock);
      s_rready = 1'b0; m_rvalid = 1'b0;
    end
    #1;
    chk("arready_done", s_arready, 1);
  endtask

  task automatic wr_burst(input logic [3:0] id, input logic [31:0] base, input int len,
                          input int size, input int burst, input int aw_dly, input int w_dly,
                          input bit fixed_data);
    logic [31:0] d;
    logic [3:0]  st;
    logic        awv, wv;
    int          aw_n, w_n, bd;
    @(negedge clock);
    chk("awready_idle", s_awready, 1);
    s_awvalid = 1'b1; s_awid = id; s_awaddr = base;
    s_awlen = 8'(len); s_awsize = 3'(size); s_awburst = 2'(burst);
    @(negedge clock);
    s_awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      d = $urandom;
      if (fixed_data) d = (b == 0) ? 32'hAABB_CCDD : 32'h1122_3344;
      st = 4'($urandom);
      s_wvalid = 1'b1; s_wdata = d; s_wstrb = st; s_wlast = (b == len);
      #1;
      chk("s_wready", s_wready, 1);
      @(negedge clock);
      s_wvalid = 1'b0;
      aw_n = 0; w_n = 0;
      for (int c = 0; c < 12 && !(aw_n > 0 && w_n > 0); c++) begin
        chk("m_awvalid", m_awvalid, (aw_n == 0));
        chk("m_wvalid", m_wvalid, (w_n == 0));
        if (aw_n == 0) chk("m_awaddr", m_awaddr, beat_addr(base, b, size, burst));
        if (w_n == 0) begin
          chk("m_wdata", m_wdata, d);
          chk("m_wstrb", m_wstrb, st);
        end
        m_awready = (c >= aw_dly);
        m_wready  = (c >= w_dly);
        awv = m_awvalid; wv = m_wvalid;
        @(negedge clock);
        if (awv && m_awready) aw_n++;
        if (wv && m_wready) w_n++;
      end
      // Readies still high: a second write would show up here.
      chk("aw_extra", m_awvalid, 0);
      chk("w_extra", m_wvalid, 0);
      chk("aw_count", aw_n, 1);
      chk("w_count", w_n, 1);
      m_awready = 1'b0; m_wready = 1'b0;
      bd = $urandom_range(0, 2);
      for (int c = 0; c <= bd; c++) begin
        chk("m_bready", m_bready, 1);
        if (c == bd) m_bvalid = 1'b1;
        else @(negedge clock);
      end
      @(negedge clock);
      m_bvalid = 1'b0;
      if (b < len) chk("no_early_b", s_bvalid, 0);
    end
    chk("s_bvalid", s_bvalid, 1);
    chk("s_bid", s_bid, id);
    chk("s_bresp", s_bresp, 0);
    @(negedge clock);
    chk("s_bvalid_hold", s_bvalid, 1);
    s_bready = 1'b1;
    @(negedge clock);
    s_bready = 1'b0;
    chk("s_bvalid_drop", s_bvalid, 0);
    chk("awready_done", s_awready, 1);
  endtask

  initial begin
    reset = 1'b1;
    s_awvalid = 0; s_awid = 0; s_awaddr = 0; s_awlen = 0; s_awsize = 0; s_awburst = 0;
    s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0; s_bready = 0;
    s_arvalid = 0; s_arid = 0; s_araddr = 0; s_arlen = 0; s_arsize = 0; s_arburst = 0;
    s_rready = 0; m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0;
    m_rvalid = 0; m_rdata = 0;
    repeat (3) @(negedge clock);
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_m_awvalid", m_awvalid, 0);
    chk("rst_m_wvalid", m_wvalid, 0);
    chk("rst_s_bvalid", s_bvalid, 0);
    chk("rst_s_rvalid", s_rvalid, 0);
    chk("rst_m_bready", m_bready, 0);
    chk("rst_m_rready", m_rready, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_arready", s_arready, 1);
    chk("idle_awready", s_awready, 1);

    rd_burst(4'd5, 32'h8000_0000, 3, 2, 1, -1, 0, -1);
    rd_burst(4'd9, 32'h8000_0100, 2, 2, 0, -1, 0, -1);
    rd_burst(4'd2, 32'h8000_0040, 3, 2, 1, 1, 4, -1);
    wr_burst(4'd7, 32'h8000_0010, 1, 2, 1, 0, 0, 1'b1);
    wr_burst(4'd3, 32'h8000_0020, 0, 2, 1, 3, 0, 1'b0);
    wr_burst(4'd4, 32'h8000_0030, 1, 2, 1, 0, 2, 1'b0);
    rd_burst(4'd1, 32'h8000_0000, 7, 2, 1, -1, 0, 2);
    rd_burst(4'd6, 32'hFFFF_FFF8, 3, 2, 1, -1, 0, -1);
    wr_burst(4'd8, 32'hFFFF_FFFC, 2, 2, 1, 1, 1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      rd_burst(4'($urandom), $urandom, $urandom_range(0, 5), $urandom_range(0, 2),
               $urandom_range(0, 1), $urandom_range(0, 5), $urandom_range(0, 2), -1);
      wr_burst(4'($urandom), $urandom, $urandom_range(0, 5), $urandom_range(0, 2),
               $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
